// File: rtl/glyph_draw_sequencer_pkg.sv
// Shared types, constants and geometry helpers for the glyph draw sequencer.
// Optional feature macro: GLYPH_CLIP_EN (clip rectangles to the 640x480 screen).
package glyph_pkg;

    localparam int          NUM_GLYPHS          = 8;
    localparam logic [31:0] GLYPH_PITCH         = 32'd128;
    localparam int          MAX_RECTS_PER_GLYPH = 4;
    localparam logic [31:0] GLYPH_UNIT          = 32'd32;
    localparam logic [31:0] SCREEN_W            = 32'd640;
    localparam logic [31:0] SCREEN_H            = 32'd480;

    typedef enum logic [1:0] {
        GLYPH_BLANK = 2'd0,
        GLYPH_I     = 2'd1,
        GLYPH_U     = 2'd2,
        GLYPH_G     = 2'd3
    } glyph_code_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_EMIT,
        ST_ADVANCE,
        ST_DONE
    } state_t;

    // Rectangle offsets in units of GLYPH_UNIT pixels from the glyph origin.
    typedef struct packed {
        logic [2:0] x0;
        logic [2:0] y0;
        logic [2:0] x1;
        logic [2:0] y1;
    } rect_off_t;

    // Absolute pixel rectangle, x0 <= x < x1, y0 <= y < y1.
    typedef struct packed {
        logic [31:0] x0;
        logic [31:0] y0;
        logic [31:0] x1;
        logic [31:0] y1;
    } rect_t;

    localparam rect_off_t RZ = '{3'd0, 3'd0, 3'd0, 3'd0};

    // Indexed [glyph code][rect index]; unused slots are zero.
    localparam rect_off_t RECT_OFFS [4][MAX_RECTS_PER_GLYPH] = '{
        '{RZ, RZ, RZ, RZ},
        '{'{3'd0, 3'd0, 3'd1, 3'd3}, RZ, RZ, RZ},
        '{'{3'd0, 3'd0, 3'd1, 3'd4}, '{3'd1, 3'd3, 3'd2, 3'd4},
          '{3'd2, 3'd0, 3'd3, 3'd4}, RZ},
        '{'{3'd0, 3'd0, 3'd3, 3'd1}, '{3'd0, 3'd1, 3'd1, 3'd3},
          '{3'd0, 3'd3, 3'd3, 3'd4}, '{3'd2, 3'd2, 3'd3, 3'd3}}
    };

    localparam logic [2:0] RECT_COUNT [4] = '{3'd0, 3'd1, 3'd3, 3'd4};

    function automatic glyph_code_t glyph_at(logic [2*NUM_GLYPHS-1:0] codes, logic [2:0] idx);
        return glyph_code_t'(codes[{idx, 1'b0} +: 2]);
    endfunction

    function automatic rect_t rect_place_off(rect_off_t o, logic [31:0] gx, logic [31:0] gy);
        rect_t rc;
        rc.x0 = gx + 32'(o.x0) * GLYPH_UNIT;
        rc.y0 = gy + 32'(o.y0) * GLYPH_UNIT;
        rc.x1 = gx + 32'(o.x1) * GLYPH_UNIT;
        rc.y1 = gy + 32'(o.y1) * GLYPH_UNIT;
        return rc;
    endfunction

    function automatic rect_t rect_place(glyph_code_t code, logic [1:0] r,
                                         logic [31:0] gx, logic [31:0] gy);
        return rect_place_off(RECT_OFFS[code][r], gx, gy);
    endfunction

    // A rect whose origin lies off-screen (including wrapped coordinates) is skipped.
    function automatic logic rect_on_screen(rect_t rc);
        return (rc.x0 < SCREEN_W) && (rc.y0 < SCREEN_H) && (rc.x1 > rc.x0) && (rc.y1 > rc.y0);
    endfunction

    function automatic rect_t rect_clip(rect_t rc);
        rect_t c;
        c    = rc;
        c.x1 = (rc.x1 > SCREEN_W) ? SCREEN_W : rc.x1;
        c.y1 = (rc.y1 > SCREEN_H) ? SCREEN_H : rc.y1;
        return c;
    endfunction

endpackage

// File: rtl/glyph_draw_sequencer_if.sv
// Rectangle stream between the glyph sequencer (master) and the rasterizer (slave).
interface glyph_draw_sequencer_if;
    logic        rect_valid;
    logic        rect_ready;
    logic [31:0] rect_x0;
    logic [31:0] rect_y0;
    logic [31:0] rect_x1;
    logic [31:0] rect_y1;
    logic        rect_last;

    modport master (
        output rect_valid, rect_x0, rect_y0, rect_x1, rect_y1, rect_last,
        input  rect_ready
    );

    modport slave (
        input  rect_valid, rect_x0, rect_y0, rect_x1, rect_y1, rect_last,
        output rect_ready
    );
endinterface

// File: rtl/glyph_draw_sequencer_rect_rom.sv
// Combinational glyph geometry lookup: (code, rect index) -> offsets, last flag, count.
module glyph_rect_rom
    import glyph_pkg::*;
(
    input  glyph_code_t i_code,
    input  logic [1:0]  i_rect,
    output rect_off_t   o_off,
    output logic        o_last,
    output logic [2:0]  o_count
);
    assign o_off   = RECT_OFFS[i_code][i_rect];
    assign o_count = RECT_COUNT[i_code];
    assign o_last  = (({1'b0, i_rect} + 3'd1) == o_count);
endmodule

// File: rtl/glyph_draw_sequencer.sv
// Walks a latched glyph string and streams each glyph's rectangles to the rasterizer.
// Optional feature macro: GLYPH_CLIP_EN (clip to screen, skip off-screen rects).
module glyph_draw_sequencer
    import glyph_pkg::*;
(
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic [31:0]             i_origin_x,
    input  logic [31:0]             i_origin_y,
    input  logic [3:0]              i_glyph_count,
    input  logic [2*NUM_GLYPHS-1:0] i_glyph_codes,
    glyph_draw_sequencer_if.master  rect_if,
    output logic                    o_busy,
    output logic                    o_done
);
    state_t                  r_state;
    state_t                  w_next_state;
    logic [3:0]              r_k;
    logic [1:0]              r_r;
    logic [3:0]              r_count;
    logic [2*NUM_GLYPHS-1:0] r_codes;
    logic [31:0]             r_ox;
    logic [31:0]             r_oy;

    glyph_code_t w_code;
    glyph_code_t w_next_code;
    logic [3:0]  w_k_next;
    rect_off_t   w_off;
    logic        w_rect_is_last;
    logic [2:0]  w_rect_count;
    logic [31:0] w_gx;
    rect_t       w_rect;
    rect_t       w_rect_out;
    logic        w_visible;
    logic        w_step;
    logic        w_more;

    assign w_code      = glyph_at(r_codes, r_k[2:0]);
    assign w_k_next    = r_k + 4'd1;
    assign w_next_code = glyph_at(r_codes, w_k_next[2:0]);
    assign w_gx        = r_ox + 32'(r_k) * GLYPH_PITCH;

    glyph_rect_rom u_rom (
        .i_code  (w_code),
        .i_rect  (r_r),
        .o_off   (w_off),
        .o_last  (w_rect_is_last),
        .o_count (w_rect_count)
    );

    assign w_rect = rect_place_off(w_off, w_gx, r_oy);

`ifdef GLYPH_CLIP_EN
    assign w_visible  = rect_on_screen(w_rect);
    assign w_rect_out = rect_clip(w_rect);
`else
    assign w_visible  = 1'b1;
    assign w_rect_out = w_rect;
`endif

    // An invisible rect is stepped over in one cycle without a handshake.
    assign w_step = !w_visible || rect_if.rect_ready;

    // Lookahead: is any emitted rect still to come after (k, r) in this banner?
    always_comb begin
        // NOTE: every combinational output gets a default first so no path can infer a latch.
        w_more = 1'b0;
        for (int j = 0; j < NUM_GLYPHS; j++) begin
            for (int q = 0; q < MAX_RECTS_PER_GLYPH; q++) begin
                if ((4'(j) < r_count) &&
                    (3'(q) < RECT_COUNT[glyph_at(r_codes, 3'(j))]) &&
                    ((4'(j) > r_k) || ((4'(j) == r_k) && (2'(q) > r_r)))) begin
`ifdef GLYPH_CLIP_EN
                    if (rect_on_screen(rect_place(glyph_at(r_codes, 3'(j)), 2'(q),
                                                  r_ox + 32'(j) * GLYPH_PITCH, r_oy)))
`endif
                    w_more = 1'b1;
                end
            end
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge i_clock) begin
        // NOTE: sequential state uses <= so every register samples pre-edge values.
        if (i_reset) r_state <= ST_IDLE;
        else         r_state <= w_next_state;
    end

    // Next-state logic.
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            ST_IDLE:    if (i_start) w_next_state = ST_LOAD;
            ST_LOAD: begin
                if (r_count == 4'd0)           w_next_state = ST_DONE;
                else if (w_rect_count == 3'd0) w_next_state = ST_ADVANCE;
                else                           w_next_state = ST_EMIT;
            end
            ST_EMIT:    if (w_step && w_rect_is_last) w_next_state = ST_ADVANCE;
            ST_ADVANCE: begin
                if (w_k_next == r_count)            w_next_state = ST_DONE;
                else if (w_next_code == GLYPH_BLANK) w_next_state = ST_ADVANCE;
                else                                 w_next_state = ST_EMIT;
            end
            ST_DONE:    w_next_state = ST_IDLE;
            default:    w_next_state = ST_IDLE;
        endcase
    end

    // Banner context latch and glyph/rect cursor.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_k     <= '0;
            r_r     <= '0;
            r_count <= '0;
            r_codes <= '0;
            r_ox    <= '0;
            r_oy    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (i_start) begin
                    r_codes <= i_glyph_codes;
                    r_ox    <= i_origin_x;
                    r_oy    <= i_origin_y;
                    r_count <= (i_glyph_count > 4'(NUM_GLYPHS)) ? 4'(NUM_GLYPHS) : i_glyph_count;
                    r_k     <= '0;
                    r_r     <= '0;
                end
                ST_EMIT: if (w_step && !w_rect_is_last) r_r <= r_r + 2'd1;
                ST_ADVANCE: begin
                    r_k <= w_k_next;
                    r_r <= '0;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from registered state only; rect fields read zero when not valid.
    always_comb begin
        rect_if.rect_valid = 1'b0;
        rect_if.rect_last  = 1'b0;
        rect_if.rect_x0    = '0;
        rect_if.rect_y0    = '0;
        rect_if.rect_x1    = '0;
        rect_if.rect_y1    = '0;
        o_busy             = (r_state != ST_IDLE);
        o_done             = (r_state == ST_DONE);
        if ((r_state == ST_EMIT) && w_visible) begin
            rect_if.rect_valid = 1'b1;
            rect_if.rect_last  = !w_more;
            rect_if.rect_x0    = w_rect_out.x0;
            rect_if.rect_y0    = w_rect_out.y0;
            rect_if.rect_x1    = w_rect_out.x1;
            rect_if.rect_y1    = w_rect_out.y1;
        end
    end

endmodule

// File: tb/tb_glyph_draw_sequencer.sv
// Self-checking bench: vector table + rect scoreboard, plus reset/start corner sequences.
module tb_glyph_draw_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] ox, oy;
    logic [3:0]  cnt;
    logic [15:0] codes;
    logic        busy, done;

    glyph_draw_sequencer_if rect_bus ();

    glyph_draw_sequencer dut (
        .i_clock       (clk),
        .i_reset       (rst),
        .i_start       (start),
        .i_origin_x    (ox),
        .i_origin_y    (oy),
        .i_glyph_count (cnt),
        .i_glyph_codes (codes),
        .rect_if       (rect_bus),
        .o_busy        (busy),
        .o_done        (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ox;
        logic [31:0] oy;
        logic [3:0]  cnt;
        logic [15:0] codes;
        int          n_plain;
        int          n_clip;
        int          first_plain;
        int          first_clip;
        int          done_t;
    } vec_t;

    typedef struct packed {
        logic [31:0] x0;
        logic [31:0] y0;
        logic [31:0] x1;
        logic [31:0] y1;
        logic        last;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input bit ok, input string name, input logic [128:0] act,
                         input logic [128:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Glyph geometry in pixels, written independently of the design's table.
    function automatic int nrects(input int code);
        case (code)
            1:       return 1;
            2:       return 3;
            3:       return 4;
            default: return 0;
        endcase
    endfunction

    task automatic bench_rect(input int code, input int r, output logic [31:0] a,
                              output logic [31:0] b, output logic [31:0] c, output logic [31:0] d);
        {a, b, c, d} = '0;
        if (code == 1) {a, b, c, d} = {32'd0, 32'd0, 32'd32, 32'd96};
        else if (code == 2) begin
            case (r)
                0: {a, b, c, d} = {32'd0,  32'd0,  32'd32, 32'd128};
                1: {a, b, c, d} = {32'd32, 32'd96, 32'd64, 32'd128};
                default: {a, b, c, d} = {32'd64, 32'd0, 32'd96, 32'd128};
            endcase
        end else if (code == 3) begin
            case (r)
                0: {a, b, c, d} = {32'd0,  32'd0,  32'd96, 32'd32};
                1: {a, b, c, d} = {32'd0,  32'd32, 32'd32, 32'd96};
                2: {a, b, c, d} = {32'd0,  32'd96, 32'd96, 32'd128};
                default: {a, b, c, d} = {32'd64, 32'd64, 32'd96, 32'd96};
            endcase
        end
    endtask

    // Push the expected rect sequence; the final pushed rect gets the last flag.
    task automatic model_push(input vec_t v);
        int          n;
        int          base;
        int          code;
        logic [31:0] gx, a, b, c, d;
        exp_t        e;
        n    = (v.cnt > 4'd8) ? 8 : int'(v.cnt);
        base = sb.size();
        for (int k = 0; k < n; k++) begin
            code = int'((v.codes >> (2 * k)) & 16'h3);
            gx   = v.ox + 32'(k * 128);
            for (int r = 0; r < nrects(code); r++) begin
                bench_rect(code, r, a, b, c, d);
                e = '{gx + a, v.oy + b, gx + c, v.oy + d, 1'b0};
`ifdef GLYPH_CLIP_EN
                if (e.x0 < 32'd640 && e.y0 < 32'd480) begin
                    if (e.x1 > 32'd640) e.x1 = 32'd640;
                    if (e.y1 > 32'd480) e.y1 = 32'd480;
                    sb.push_back(e);
                end
`else
                sb.push_back(e);
`endif
            end
        end
        if (sb.size() > base) begin
            e      = sb.pop_back();
            e.last = 1'b1;
            sb.push_back(e);
        end
    endtask

    function automatic exp_t observed();
        return '{rect_bus.rect_x0, rect_bus.rect_y0, rect_bus.rect_x1, rect_bus.rect_y1,
                 rect_bus.rect_last};
    endfunction

    // Run one table vector; caller leaves the bench just after a negedge with DUT idle.
    task automatic run_vec(input int idx, input bit toggle);
        vec_t v;
        int   t, n_xfer, exp_n, exp_first, first_t;
        bit   seen_done, prev_stall;
        exp_t cur, prev, e;
        v = vecs[idx];
`ifdef GLYPH_CLIP_EN
        exp_n     = v.n_clip;
        exp_first = v.first_clip;
`else
        exp_n     = v.n_plain;
        exp_first = v.first_plain;
`endif
        model_push(v);
        check(!busy, $sformatf("v%0d idle_before_start", idx), 129'(busy), 129'(0));
        ox = v.ox; oy = v.oy; cnt = v.cnt; codes = v.codes;
        start = 1'b1;
        rect_bus.rect_ready = 1'b1;
        t = 0; n_xfer = 0; first_t = 0; seen_done = 1'b0; prev_stall = 1'b0; prev = '0;
        while (!seen_done && t < 300) begin
            @(negedge clk);
            t++;
            if (t == 1) begin
                // start while busy, with scrambled inputs, must not disturb the banner
                start = 1'b1;
                ox = $urandom; oy = $urandom; cnt = 4'($urandom); codes = 16'($urandom);
            end
            if (t == 2) start = 1'b0;
            rect_bus.rect_ready = toggle ? t[0] : 1'b1;
            cur = observed();
            if (t == 1)
                check(busy && !rect_bus.rect_valid, $sformatf("v%0d load_cycle", idx),
                      129'({busy, rect_bus.rect_valid}), 129'(2'b10));
            if (prev_stall)
                check(rect_bus.rect_valid && cur == prev, $sformatf("v%0d stall_hold t%0d", idx, t),
                      129'(cur), 129'(prev));
            if (rect_bus.rect_valid && first_t == 0) first_t = t;
            if (rect_bus.rect_valid && rect_bus.rect_ready) begin
                n_xfer++;
                if (sb.size() == 0) check(1'b0, $sformatf("v%0d extra_rect", idx), 129'(cur), 129'(0));
                else begin
                    e = sb.pop_front();
                    check(cur == e, $sformatf("v%0d rect%0d", idx, n_xfer), 129'(cur), 129'(e));
                end
            end
            prev_stall = rect_bus.rect_valid && !rect_bus.rect_ready;
            prev       = cur;
            if (done) seen_done = 1'b1;
        end
        check(seen_done, $sformatf("v%0d done_seen", idx), 129'(seen_done), 129'(1));
        check(n_xfer == exp_n, $sformatf("v%0d rect_count", idx), 129'(n_xfer), 129'(exp_n));
        if (!toggle)
            check(t == v.done_t, $sformatf("v%0d done_cycle", idx), 129'(t), 129'(v.done_t));
        if (exp_first == 0)
            check(first_t == 0, $sformatf("v%0d no_valid", idx), 129'(first_t), 129'(0));
        else if (!toggle)
            check(first_t == exp_first, $sformatf("v%0d first_valid", idx), 129'(first_t),
                  129'(exp_first));
        @(negedge clk);
        check(!busy && !done, $sformatf("v%0d idle_after_done", idx), 129'({busy, done}), 129'(0));
        sb.delete();
    endtask

    initial begin
        int   bad;
        exp_t cur;
        vecs[0] = '{32'd100,        32'd50,  4'd1,  16'h0001, 1, 1, 2, 2, 4};
        vecs[1] = '{32'd0,          32'd0,   4'd3,  16'h0036, 8, 8, 2, 2, 13};
        vecs[2] = '{32'd0,          32'd0,   4'd2,  16'h0000, 0, 0, 0, 0, 4};
        vecs[3] = '{32'd0,          32'd0,   4'd0,  16'hFFFF, 0, 0, 0, 0, 2};
        vecs[4] = '{32'd10,         32'd20,  4'd15, 16'h5555, 8, 5, 2, 2, 18};
        vecs[5] = '{32'hFFFF_FF80,  32'd5,   4'd2,  16'h0005, 2, 1, 2, 4, 6};
        vecs[6] = '{32'd600,        32'd400, 4'd1,  16'h0002, 3, 1, 2, 2, 6};
        vecs[7] = '{32'd64,         32'd16,  4'd3,  16'h0001, 1, 1, 2, 2, 6};

        rst = 1'b1; start = 1'b0; ox = '0; oy = '0; cnt = '0; codes = '0;
        rect_bus.rect_ready = 1'b0;
        repeat (3) @(negedge clk);
        cur = observed();
        check({rect_bus.rect_valid, busy, done} == 3'b000 && cur == '0, "reset_outputs",
              129'({rect_bus.rect_valid, busy, done, cur}), 129'(0));
        rst = 1'b0;
        @(negedge clk);
        check(!busy, "idle_after_reset", 129'(busy), 129'(0));

        for (int i = 0; i < 8; i++) run_vec(i, 1'b0);
        run_vec(1, 1'b1);
        run_vec(6, 1'b1);

        // Reset during the second rect of U aborts the banner with no done pulse.
        ox = 32'd0; oy = 32'd0; cnt = 4'd1; codes = 16'h0002; start = 1'b1;
        rect_bus.rect_ready = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check(rect_bus.rect_valid && rect_bus.rect_x0 == 32'd32 && rect_bus.rect_y0 == 32'd96,
              "u_second_rect", 129'({rect_bus.rect_valid, rect_bus.rect_x0, rect_bus.rect_y0}),
              129'({1'b1, 32'd32, 32'd96}));
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        cur = observed();
        check({rect_bus.rect_valid, busy, done} == 3'b000 && cur == '0, "reset_abort_outputs",
              129'({rect_bus.rect_valid, busy, done, cur}), 129'(0));
        rst = 1'b0; start = 1'b0;
        bad = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || busy || rect_bus.rect_valid) bad++;
        end
        check(bad == 0, "no_done_after_abort", 129'(bad), 129'(0));

        // start and reset in the same idle cycle: reset wins.
        ox = 32'd100; oy = 32'd50; cnt = 4'd1; codes = 16'h0001;
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        check(!busy, "reset_beats_start", 129'(busy), 129'(0));
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check(!busy, "still_idle", 129'(busy), 129'(0));

        run_vec(0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
